// File: rtl/eth_spi_pkg.sv
// Shared definitions for the Ethernet-controller SPI master: register map,
// field positions and FSM states.
package eth_spi_pkg;

  localparam int ADDR_W = 2;
  localparam int BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;

  localparam int CTRL_CS      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_W   = 8;

  // Smallest divider that still leaves room for the SO synchroniser delay.
  localparam logic [CTRL_DIV_W-1:0] DIV_MIN = 8'd2;

  typedef enum logic [1:0] {
    IDLE,
    SCK_LO,
    SCK_HI
  } spi_state_e;

  function automatic logic [CTRL_DIV_W-1:0] clamp_div(input logic [CTRL_DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/eth_spi_master_if.sv
// Avalon-MM register port of the SPI master; the CPU side is the master.
interface eth_spi_master_if;
  import eth_spi_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/eth_spi_sync2.sv
// Two-flop synchroniser for one asynchronous input, cleared by reset.
module eth_spi_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eth_spi_master.sv
// Mode-0, MSB-first SPI master with an Avalon-MM register bank; drives the
// Ethernet controller's SCK/SI/CS_n and captures its SO line.
module eth_spi_master
  import eth_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV_DEFAULT = 4,
  parameter int unsigned DATA_W          = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  eth_spi_master_if.slave bus,
  output logic            spi_sck,
  output logic            spi_si,
  input  logic            spi_so,
  output logic            spi_cs_n,
  output logic            irq
);

  localparam int BIT_W = $clog2(DATA_W);

  spi_state_e            state_q;
  logic [CTRL_DIV_W-1:0] div_q, div_d;
  logic [CTRL_DIV_W-1:0] xfer_div_q;
  logic [CTRL_DIV_W-1:0] phase_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_W-1:0]     tx_q;
  logic [DATA_W-1:0]     rx_shift_q;
  logic [DATA_W-1:0]     rxdata_q;
  logic [DATA_W-1:0]     rx_next;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  cs_assert_q, cs_assert_d;
  logic                  irq_en_q, irq_en_d;
  logic                  sck_q, si_q, cs_n_q, irq_q;
  logic [BUS_W-1:0]      readdata_q, readdata_d;

  logic so_sync;
  logic wr_en, wr_data, wr_status, wr_ctrl;
  logic busy, start, phase_end, last_bit_end;
  logic unused_wdata;

  eth_spi_sync2 u_so_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (spi_so),
    .q_o     (so_sync)
  );

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr_en && (bus.address == ADDR_DATA);
  assign wr_status = wr_en && (bus.address == ADDR_STATUS);
  assign wr_ctrl   = wr_en && (bus.address == ADDR_CONTROL);

  assign busy         = (state_q != IDLE);
  assign start        = wr_data && !busy;
  assign phase_end    = (phase_q == xfer_div_q);
  assign last_bit_end = (state_q == SCK_HI) && phase_end && (bit_q == '0);
  assign rx_next      = {rx_shift_q[DATA_W-2:0], so_sync};

  assign unused_wdata = ^bus.writedata[BUS_W-1:CTRL_DIV_LSB+CTRL_DIV_W];

  // Status sets are applied after the W1C clear so a coincident set wins.
  always_comb begin : reg_next
    done_d      = done_q;
    overrun_d   = overrun_q;
    cs_assert_d = cs_assert_q;
    irq_en_d    = irq_en_q;
    div_d       = div_q;
    if (wr_status) begin
      if (bus.writedata[ST_DONE])    done_d    = 1'b0;
      if (bus.writedata[ST_OVERRUN]) overrun_d = 1'b0;
    end
    if (last_bit_end)    done_d    = 1'b1;
    if (wr_data && busy) overrun_d = 1'b1;
    if (wr_ctrl) begin
      cs_assert_d = bus.writedata[CTRL_CS];
      irq_en_d    = bus.writedata[CTRL_IRQ_EN];
      div_d       = clamp_div(bus.writedata[CTRL_DIV_LSB +: CTRL_DIV_W]);
    end
  end

  always_comb begin : read_mux
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d[DATA_W-1:0] = rxdata_q;
      ADDR_STATUS: begin
        readdata_d[ST_BUSY]    = busy;
        readdata_d[ST_DONE]    = done_q;
        readdata_d[ST_OVERRUN] = overrun_q;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_CS]                         = cs_assert_q;
        readdata_d[CTRL_IRQ_EN]                     = irq_en_q;
        readdata_d[CTRL_DIV_LSB +: CTRL_DIV_W]      = div_q;
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= CTRL_DIV_W'(CLK_DIV_DEFAULT);
      xfer_div_q  <= CTRL_DIV_W'(CLK_DIV_DEFAULT);
      phase_q     <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_shift_q  <= '0;
      rxdata_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cs_assert_q <= 1'b0;
      irq_en_q    <= 1'b0;
      sck_q       <= 1'b0;
      si_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      cs_assert_q <= cs_assert_d;
      irq_en_q    <= irq_en_d;
      div_q       <= div_d;
      cs_n_q      <= ~cs_assert_d;
      irq_q       <= irq_en_d & done_d;
      readdata_q  <= readdata_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SCK_LO;
            tx_q       <= bus.writedata[DATA_W-1:0];
            si_q       <= bus.writedata[DATA_W-1];
            xfer_div_q <= div_q;
            phase_q    <= '0;
            bit_q      <= BIT_W'(DATA_W - 1);
          end
        end
        SCK_LO: begin
          if (phase_end) begin
            phase_q <= '0;
            sck_q   <= 1'b1;
            state_q <= SCK_HI;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SCK_HI: begin
          if (phase_end) begin
            phase_q    <= '0;
            sck_q      <= 1'b0;
            rx_shift_q <= rx_next;
            if (bit_q == '0) begin
              state_q  <= IDLE;
              rxdata_q <= rx_next;
            end else begin
              bit_q   <= bit_q - BIT_W'(1);
              tx_q    <= {tx_q[DATA_W-2:0], 1'b0};
              si_q    <= tx_q[DATA_W-2];
              state_q <= SCK_LO;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign spi_sck      = sck_q;
  assign spi_si       = si_q;
  assign spi_cs_n     = cs_n_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_eth_spi_master.sv
// Scoreboard bench for eth_spi_master: register reads and SI bits are queued
// as expectations and checked by independent monitors.
module tb_eth_spi_master;
  import eth_spi_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic spi_sck, spi_si, spi_so, spi_cs_n, irq;

  eth_spi_master_if bus ();

  eth_spi_master #(.CLK_DIV_DEFAULT(4), .DATA_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_sck  (spi_sck),
    .spi_si   (spi_si),
    .spi_so   (spi_so),
    .spi_cs_n (spi_cs_n),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_item_t;

  rd_item_t rd_q [$];
  logic     si_q [$];
  logic     rd_req = 1'b0;
  logic     rd_vld = 1'b0;

  // Mode-0 slave: presents the response MSB first, advances on SCK fall.
  logic [7:0] slv_rsp   = 8'h00;
  int         slv_falls = 0;
  int         slv_base  = 0;

  function automatic logic slv_bit(input logic [7:0] r, input int k);
    if (k < 0 || k > 7) return 1'b0;
    return r[7-k];
  endfunction

  assign spi_so = slv_bit(slv_rsp, slv_falls - slv_base);

  always @(negedge spi_sck) slv_falls++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: readdata is valid the cycle after a requested read.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    rd_item_t it;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got read 0x%08h, want no pending read", bus.readdata);
      end else begin
        it = rd_q.pop_front();
        check(it.name, bus.readdata, it.exp);
      end
    end
  end

  // SI monitor: the slave samples SI on every SCK rise.
  always @(posedge spi_sck) begin
    logic e;
    #1;
    if (si_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL si_unexpected: got SCK rise with SI=%0b, want no SCK activity", spi_si);
    end else begin
      e = si_q.pop_front();
      check("si_bit", {31'b0, spi_si}, {31'b0, e});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = ADDR_STATUS;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    rd_item_t it;
    @(negedge clk);
    bus.address = a;
    rd_req      = 1'b1;
    it.name     = name;
    it.exp      = exp;
    rd_q.push_back(it);
    @(negedge clk);
    rd_req      = 1'b0;
    bus.address = ADDR_STATUS;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rsp);
    slv_rsp  = rsp;
    slv_base = slv_falls;
    for (int i = 7; i >= 0; i--) si_q.push_back(tx[i]);
    bus_write(ADDR_DATA, {24'b0, tx});
  endtask

  // Polls STATUS.busy through readdata (address parked on STATUS) and
  // measures SCK high/low run lengths at the same time.
  task automatic wait_idle(input int h, input bit chk, input string tag);
    int   busy_n = 0;
    int   pulses = 0;
    int   bad    = 0;
    int   hi     = 0;
    int   lo     = 0;
    logic prev   = 1'b0;
    bit   seen   = 1'b0;
    bit   idle   = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (spi_sck && !prev) begin
        pulses++;
        if (pulses > 1 && lo != h) bad++;
        hi = 0;
      end else if (!spi_sck && prev) begin
        if (hi != h) bad++;
        lo = 0;
      end
      if (spi_sck) hi++; else lo++;
      prev = spi_sck;
      if (bus.readdata[ST_BUSY]) begin
        busy_n++;
        seen = 1'b1;
      end else if (seen || !chk) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_idle_reached"}, {31'b0, idle}, 32'd1);
    if (chk) begin
      check({tag, "_busy_cycles"}, busy_n, 16 * h);
      check({tag, "_sck_pulses"}, pulses, 32'd8);
      check({tag, "_sck_bad_runs"}, bad, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int   rises;
    logic prev;
    bus.address    = ADDR_STATUS;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    #3 reset_n = 1'b0;
    #1;
    check("rst_readdata", bus.readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("rst_sck", {31'b0, spi_sck}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    bus_read(ADDR_CONTROL, 32'h0000_0400, "rst_control");
    bus_read(ADDR_STATUS, 32'h0, "rst_status");
    bus_read(ADDR_DATA, 32'h0, "rst_data");

    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'h0, "reserved_read");
    bus_read(ADDR_CONTROL, 32'h0000_0400, "reserved_no_effect");

    // Basic transfer, H = 3.
    bus_write(ADDR_CONTROL, 32'h0000_0201);
    check("cs_assert", {31'b0, spi_cs_n}, 32'd0);
    start_xfer(8'hA5, 8'h3C);
    wait_idle(3, 1'b1, "basic");
    check("basic_si_hold", {31'b0, spi_si}, 32'd1);
    check("basic_irq_off", {31'b0, irq}, 32'd0);
    check("basic_cs_held", {31'b0, spi_cs_n}, 32'd0);
    bus_read(ADDR_DATA, 32'h0000_003C, "basic_rx");
    bus_read(ADDR_STATUS, 32'h0000_0002, "basic_status");
    bus_write(ADDR_STATUS, 32'h0000_0002);

    // Overrun: a second DATA write while busy is dropped.
    start_xfer(8'hC3, 8'h96);
    repeat (8) @(negedge clk);
    bus_write(ADDR_DATA, 32'h0000_0055);
    bus_read(ADDR_STATUS, 32'h0000_0005, "ovr_status_busy");
    wait_idle(3, 1'b0, "ovr");
    bus_read(ADDR_STATUS, 32'h0000_0006, "ovr_status_after");
    bus_read(ADDR_DATA, 32'h0000_0096, "ovr_rx");
    bus_write(ADDR_STATUS, 32'h0000_0006);
    bus_read(ADDR_STATUS, 32'h0, "ovr_cleared");

    // Divider clamp: div=0 is stored as 2.
    bus_write(ADDR_CONTROL, 32'h0000_0001);
    bus_read(ADDR_CONTROL, 32'h0000_0201, "clamp_control");
    start_xfer(8'h3C, 8'hC3);
    wait_idle(3, 1'b1, "clamp");
    bus_read(ADDR_DATA, 32'h0000_00C3, "clamp_rx");
    bus_write(ADDR_STATUS, 32'h0000_0002);

    // Interrupt.
    bus_write(ADDR_CONTROL, 32'h0000_0203);
    bus_read(ADDR_CONTROL, 32'h0000_0203, "irq_control");
    check("irq_idle", {31'b0, irq}, 32'd0);
    start_xfer(8'h81, 8'h7E);
    wait_idle(3, 1'b1, "irq");
    check("irq_set", {31'b0, irq}, 32'd1);
    bus_read(ADDR_DATA, 32'h0000_007E, "irq_rx");
    bus_write(ADDR_STATUS, 32'h0000_0002);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    bus_read(ADDR_STATUS, 32'h0, "irq_status_clear");

    // W1C of done in the very cycle done is set: the set wins.
    start_xfer(8'h18, 8'h42);
    repeat (46) @(negedge clk);
    bus_write(ADDR_STATUS, 32'h0000_0002);
    wait_idle(3, 1'b0, "race");
    bus_read(ADDR_STATUS, 32'h0000_0002, "race_done_kept");
    check("race_irq", {31'b0, irq}, 32'd1);
    bus_read(ADDR_DATA, 32'h0000_0042, "race_rx");
    bus_write(ADDR_STATUS, 32'h0000_0002);

    // Asynchronous reset in the middle of a transfer.
    start_xfer(8'hF0, 8'h0F);
    rises = 0;
    prev  = spi_sck;
    for (int c = 0; c < 200 && rises < 4; c++) begin
      @(negedge clk);
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
    end
    check("mid_rises", rises, 32'd4);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sck", {31'b0, spi_sck}, 32'd0);
    check("mid_rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    check("mid_rst_readdata", bus.readdata, 32'h0);
    si_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_DATA, 32'h0, "mid_rx_discarded");
    bus_read(ADDR_STATUS, 32'h0, "mid_status");
    bus_read(ADDR_CONTROL, 32'h0000_0400, "mid_control");

    repeat (4) @(negedge clk);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("si_queue_drained", si_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
